// File: rtl/hist_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hist_dump_pkg
// Description : Shared states, frame header bytes and sizing helper for the
//               histogram UART dumper.
// Revision    : 1.0 - initial release
// ============================================================================
package hist_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_FETCH   = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_SEND    = 3'd5,
        ST_CKSUM   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;

    // Bytes needed to carry one counter of the given width.
    function automatic int nbytes(input int cnt_w);
        return (cnt_w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART transmitter for one byte at a time, ready again in
//               the last stop-bit cycle so bytes can be chained seamlessly.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic              r_active;
    logic [9:0]        r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic              w_bit_end;

    assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx_ready  = !r_active || (w_bit_end && (r_bit == 4'd9));
    assign uart_tx   = r_shift[0];

    // Idle shift register holds all ones so the line rests high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_shift  <= '1;
            r_baud   <= '0;
            r_bit    <= '0;
        end else if (tx_valid && tx_ready) begin
            r_active <= 1'b1;
            r_shift  <= {1'b1, tx_data, 1'b0};
            r_baud   <= '0;
            r_bit    <= '0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_shift  <= '1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hist_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : hist_uart_dumper
// Description : Walks a frozen histogram through its read port and streams
//               header, big-endian bin counts and an XOR checksum over UART.
// Revision    : 1.0 - initial release
// ============================================================================
module hist_uart_dumper #(
    parameter int NUM_OUT      = 3,
    parameter int CNT_W        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [NUM_OUT-1:0] rd_addr,
    input  logic [CNT_W-1:0]   rd_data,
    output logic               uart_tx,
    output logic               busy,
    output logic               done
);

    import hist_dump_pkg::*;

    localparam int NB     = nbytes(CNT_W);
    localparam int WORD_W = NB * 8;
    localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int BIN_W  = NUM_OUT + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_start_q;
    logic [BIN_W-1:0]    r_bin;
    logic [BIN_W-1:0]    w_bin_next;
    logic [IDX_W-1:0]    r_byte_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [WORD_W-1:0]   r_word;
    logic [7:0]          r_cksum;
    logic [7:0]          w_cksum_next;
    logic                r_tail;
    logic                w_tail_next;
    logic                w_load_addr;
    logic                w_latch;
    logic                w_shift_word;
    logic                w_tx_valid;
    logic [7:0]          w_tx_data;
    logic                w_tx_ready;
    logic                w_edge;
    logic [7:0]          w_cur_byte;

    assign w_edge     = start & ~r_start_q;
    assign w_cur_byte = r_word[WORD_W-1 -: 8];
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Each byte-carrying state hands the next byte over on tx_ready, which the
    // transmitter raises in the final stop-bit cycle of the byte in flight.
    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_idx_next   = r_byte_idx;
        w_cksum_next = r_cksum;
        w_tail_next  = r_tail;
        w_load_addr  = 1'b0;
        w_latch      = 1'b0;
        w_shift_word = 1'b0;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_tx_valid   = 1'b1;
                    w_tx_data    = HDR0;
                    w_bin_next   = '0;
                    w_cksum_next = 8'h00;
                    w_tail_next  = 1'b0;
                    w_state_next = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (w_tx_ready) begin
                    w_tx_valid   = 1'b1;
                    w_tx_data    = HDR1;
                    w_state_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                w_load_addr  = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                w_latch      = 1'b1;
                w_idx_next   = '0;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_tx_ready) begin
                    w_tx_valid   = 1'b1;
                    w_tx_data    = w_cur_byte;
                    w_cksum_next = r_cksum ^ w_cur_byte;
                    w_shift_word = 1'b1;
                    if (r_byte_idx == IDX_W'(NB - 1)) begin
                        // The extra counter bit flags completion of the last bin.
                        w_bin_next = r_bin + BIN_W'(1);
                        if (w_bin_next[NUM_OUT]) begin
                            w_state_next = ST_CKSUM;
                        end else begin
                            w_load_addr  = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                    end else begin
                        w_idx_next = r_byte_idx + IDX_W'(1);
                    end
                end
            end
            ST_CKSUM: begin
                if (w_tx_ready) begin
                    if (!r_tail) begin
                        w_tx_valid  = 1'b1;
                        w_tx_data   = r_cksum;
                        w_tail_next = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q  <= 1'b0;
            r_bin      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_cksum    <= 8'h00;
            r_tail     <= 1'b0;
            rd_addr    <= '0;
        end else begin
            r_start_q  <= start;
            r_bin      <= w_bin_next;
            r_byte_idx <= w_idx_next;
            r_cksum    <= w_cksum_next;
            r_tail     <= w_tail_next;
            if (w_latch) begin
                r_word <= WORD_W'(rd_data);
            end else if (w_shift_word) begin
                r_word <= r_word << 8;
            end
            if (w_load_addr) begin
                rd_addr <= w_bin_next[NUM_OUT-1:0];
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (w_tx_data),
        .tx_valid (w_tx_valid),
        .tx_ready (w_tx_ready),
        .uart_tx  (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_hist_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_hist_uart_dumper
// Description : Three dumper configurations checked cycle by cycle against a
//               frame-level model of the serial stream, plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_uart_dumper;

    localparam int CPB = 4;
    localparam logic [7:0] EXP0 [11] = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h02,
                                         8'h00, 8'h03, 8'h01, 8'h00, 8'h01};

    logic            clk;
    logic [2:0]      start;
    logic [2:0]      rst_v;
    logic [2:0]      tx;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0][2:0] rd_addr_v;
    logic [15:0]     mem [3][8];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: 4 bins x 16 bit, 1: 4 bins x 12 bit, 2: 8 bins x 16 bit.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NO = (g == 2) ? 3 : 2;
        localparam int CW = (g == 1) ? 12 : 16;
        logic [NO-1:0] addr;
        logic [NO-1:0] prev;
        logic          moved;
        logic [CW-1:0] q;

        hist_uart_dumper #(
            .NUM_OUT      (NO),
            .CNT_W        (CW),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk     (clk),
            .reset   (rst_v[g]),
            .start   (start[g]),
            .rd_addr (addr),
            .rd_data (q),
            .uart_tx (tx[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );

        assign rd_addr_v[g] = 3'(addr);

        // Synchronous RAM whose data is only valid the cycle after an address
        // change; address 0 straight out of reset counts as freshly presented.
        always @(posedge clk) begin
            prev <= addr;
            if (addr != '0) moved <= 1'b1;
            if (rst_v[g]) moved <= 1'b0;
            if (addr != prev) q <= CW'(mem[g][addr]);
            else if (addr == '0 && !moved) q <= CW'(mem[g][0]);
            else q <= 'x;
        end
    end

    function automatic int cfg_no(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int cfg_cw(input int i);
        return (i == 1) ? 12 : 16;
    endfunction

    function automatic int frame_len(input int i);
        return 3 + ((cfg_cw(i) + 7) / 8) * (1 << cfg_no(i));
    endfunction

    function automatic int frame_cycles(input int i);
        return frame_len(i) * 10 * CPB;
    endfunction

    function automatic logic [7:0] bin_byte(input int i, input int j);
        int          nb;
        logic [31:0] w;
        nb = (cfg_cw(i) + 7) / 8;
        w  = 32'(mem[i][j / nb]) & ((32'd1 << cfg_cw(i)) - 32'd1);
        return 8'(w >> (8 * (nb - 1 - (j % nb))));
    endfunction

    function automatic logic [7:0] frame_byte(input int i, input int idx);
        logic [7:0] x;
        int         nbin;
        nbin = frame_len(i) - 3;
        if (idx == 0) return 8'hA5;
        if (idx == 1) return 8'h5A;
        if (idx < 2 + nbin) return bin_byte(i, idx - 2);
        x = 8'h00;
        for (int j = 0; j < nbin; j++) x ^= bin_byte(i, j);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level model: phase 0 idle, 1 dumping (k = cycle within frame), 2 done.
    task automatic monitor();
        int         ph [3];
        int         k [3];
        logic       sq [3];
        logic       s_start [3];
        logic [7:0] b;
        int         bp;
        logic       etx;
        logic       ebusy;
        logic       edone;
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; k[i] = 0; sq[i] = 1'b0; s_start[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_v[i]) begin
                    ph[i] = 0;
                    sq[i] = 1'b0;
                end else begin
                    case (ph[i])
                        0: if (s_start[i] && !sq[i]) begin ph[i] = 1; k[i] = 0; end
                        1: begin
                            k[i]++;
                            if (k[i] == frame_cycles(i)) ph[i] = 2;
                        end
                        default: if (!s_start[i]) ph[i] = 0;
                    endcase
                    sq[i] = s_start[i];
                end
                s_start[i] = start[i];
                etx   = 1'b1;
                ebusy = (ph[i] == 1);
                edone = (ph[i] == 2);
                if (ph[i] == 1) begin
                    b  = frame_byte(i, k[i] / (10 * CPB));
                    bp = (k[i] / CPB) % 10;
                    etx = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : b[bp-1];
                end
                check($sformatf("uart_tx[%0d] ph=%0d k=%0d", i, ph[i], k[i]), 32'(tx[i]), 32'(etx));
                check($sformatf("busy[%0d] ph=%0d k=%0d", i, ph[i], k[i]), 32'(busy[i]), 32'(ebusy));
                check($sformatf("done[%0d] ph=%0d k=%0d", i, ph[i], k[i]), 32'(done[i]), 32'(edone));
            end
        end
    endtask

    task automatic count_busy(input int i, input string name);
        int cnt;
        check({name, " busy rise"}, 32'(busy[i]), 32'd1);
        cnt = 0;
        while (busy[i] && cnt < 3000) begin
            cnt++;
            tick(1);
        end
        check({name, " busy cycles"}, cnt, 32'd440);
        check({name, " done rise"}, 32'(done[i]), 32'd1);
    endtask

    task automatic stimulus();
        int cnt;
        tick(3);
        check("reset uart_tx", 32'(tx), 32'h7);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) check($sformatf("reset rd_addr[%0d]", i), 32'(rd_addr_v[i]), 32'h0);

        for (int j = 0; j < 11; j++) check($sformatf("model basic byte %0d", j), 32'(frame_byte(0, j)), 32'(EXP0[j]));
        check("model odd bin0 hi", 32'(frame_byte(1, 2)), 32'h0F);
        check("model odd bin0 lo", 32'(frame_byte(1, 3)), 32'hFF);
        check("model odd cksum", 32'(frame_byte(1, 10)), 32'hF0);
        check("model max cksum", 32'(frame_byte(2, 18)), 32'h00);
        check("model max len", frame_len(2), 32'd19);
        check("model basic cycles", frame_cycles(0), 32'd440);
        check("model max cycles", frame_cycles(2), 32'd760);

        rst_v = 3'b000;
        tick(2);
        start = 3'b111;
        tick(1);
        check("first busy", 32'(busy), 32'h7);
        cnt = 0;
        while (busy[0] && cnt < 3000) begin
            cnt++;
            if (cnt == 100) start[1] = 1'b0;
            if (cnt == 102) start[1] = 1'b1;
            tick(1);
        end
        check("basic busy cycles", cnt, 32'd440);
        check("basic done", 32'(done[0]), 32'd1);
        check("odd done", 32'(done[1]), 32'd1);
        check("basic last addr", 32'(rd_addr_v[0]), 32'd3);
        while (busy[2] && cnt < 3000) begin
            cnt++;
            tick(1);
        end
        check("max busy cycles", cnt, 32'd760);
        check("max done", 32'(done[2]), 32'd1);
        check("max last addr", 32'(rd_addr_v[2]), 32'd7);

        tick(100);
        check("held start busy", 32'(busy), 32'h0);
        check("held start done", 32'(done), 32'h7);

        start[0] = 1'b0;
        tick(3);
        check("done clears", 32'(done[0]), 32'd0);
        start[0] = 1'b1;
        tick(1);
        count_busy(0, "second frame");

        start[0] = 1'b0;
        tick(3);
        start[0] = 1'b1;
        tick(1);
        tick(173);
        check("pre-reset rd_addr", 32'(rd_addr_v[0]), 32'd1);
        rst_v[0] = 1'b1;
        #1;
        check("abort uart_tx", 32'(tx[0]), 32'd1);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort rd_addr", 32'(rd_addr_v[0]), 32'd0);
        start[0] = 1'b0;
        tick(2);
        rst_v[0] = 1'b0;
        tick(2);
        start[0] = 1'b1;
        tick(1);
        count_busy(0, "after reset frame");
        tick(5);
    endtask

    initial begin
        start = 3'b000;
        rst_v = 3'b111;
        for (int j = 0; j < 8; j++) begin
            mem[0][j] = 16'h0000;
            mem[1][j] = 16'h0000;
            mem[2][j] = 16'hFFFF;
        end
        mem[0][0] = 16'h0001; mem[0][1] = 16'h0002; mem[0][2] = 16'h0003; mem[0][3] = 16'h0100;
        mem[1][0] = 16'h0FFF; mem[1][1] = 16'h0002; mem[1][2] = 16'h0003; mem[1][3] = 16'h0100;
        fork
            monitor();
            stimulus();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
